// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I pipeline.
//   - Applies hazard-unit forwarding selects to the ID/EX operands.
//   - Runs the ALU, resolves branches/jumps and drives the fetch redirect.
//   - Registers results into the EX/MEM pipeline register (one-cycle latency).
// Ports:
//   clk_i, rst_i             clock, async active-high reset (clears EX/MEM)
//   *_E_i                    ID/EX register contents
//   FWD_A_i, FWD_B_i         forwarding selects (01 = W result, 10 = M ALU result)
//   RESLT_DATA_W_i           write-back result for forwarding
//   PCSRC_E_o, PCTARGET_E_o  combinational fetch redirect
//   RS1_H_o..RSLTSRC0_H_o    combinational taps to the hazard unit
//   *_M_o                    registered EX/MEM outputs
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            REGWRT_E_i,
    input  logic [1:0]      JUMP_E_i,
    input  logic [2:0]      BRANCH_E_i,
    input  logic [1:0]      RSLTSRC_E_i,
    input  logic            MEMWRT_E_i,
    input  logic [3:0]      ALUCTRL_E_i,
    input  logic            ALUSRC_E_i,
    input  logic [XLEN-1:0] RD1_E_i,
    input  logic [XLEN-1:0] RD2_E_i,
    input  logic [4:0]      RS1_E_i,
    input  logic [4:0]      RS2_E_i,
    input  logic [4:0]      RD_E_i,
    input  logic [XLEN-1:0] PC_E_i,
    input  logic [XLEN-1:0] IMM_E_i,
    input  logic [XLEN-1:0] PCPLUS4_E_i,
    input  logic [1:0]      FWD_A_i,
    input  logic [1:0]      FWD_B_i,
    input  logic [XLEN-1:0] RESLT_DATA_W_i,
    output logic            PCSRC_E_o,
    output logic [XLEN-1:0] PCTARGET_E_o,
    output logic [4:0]      RS1_H_o,
    output logic [4:0]      RS2_H_o,
    output logic [4:0]      RD_H_o,
    output logic            RSLTSRC0_H_o,
    output logic [XLEN-1:0] ALURSLT_M_o,
    output logic [XLEN-1:0] WRTDATA_M_o,
    output logic [4:0]      RD_M_o,
    output logic            REGWRT_M_o,
    output logic            MEMWRT_M_o,
    output logic [1:0]      RSLTSRC_M_o,
    output logic [XLEN-1:0] PCPLUS4_M_o
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res;
    logic [4:0]      shamt;
    logic            br_taken;

    logic [XLEN-1:0] alurslt_d, alurslt_q, wrtdata_d, wrtdata_q, pcplus4_d, pcplus4_q;
    logic [4:0]      rd_d, rd_q;
    logic            regwrt_d, regwrt_q, memwrt_d, memwrt_q;
    logic [1:0]      rsltsrc_d, rsltsrc_q;

    // Forwarding muxes; 10 picks the value registered last cycle in EX/MEM.
    always_comb begin
        case (FWD_A_i)
            2'b01:   src_a = RESLT_DATA_W_i;
            2'b10:   src_a = alurslt_q;
            default: src_a = RD1_E_i;
        endcase
        case (FWD_B_i)
            2'b01:   fwd_b = RESLT_DATA_W_i;
            2'b10:   fwd_b = alurslt_q;
            default: fwd_b = RD2_E_i;
        endcase
        src_b = ALUSRC_E_i ? IMM_E_i : fwd_b;
        shamt = src_b[4:0];
    end

    always_comb begin
        case (ALUCTRL_E_i)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = src_a << shamt;
            4'b0110: alu_res = src_a >> shamt;
            4'b0111: alu_res = $unsigned($signed(src_a) >>> shamt);
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'b1010: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    // Branch compare always uses the forwarded register operands, never IMM.
    always_comb begin
        case (BRANCH_E_i)
            3'b001:  br_taken = (src_a == fwd_b);
            3'b010:  br_taken = (src_a != fwd_b);
            3'b011:  br_taken = ($signed(src_a) <  $signed(fwd_b));
            3'b100:  br_taken = ($signed(src_a) >= $signed(fwd_b));
            3'b101:  br_taken = (src_a <  fwd_b);
            3'b110:  br_taken = (src_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
        PCSRC_E_o    = (JUMP_E_i == 2'b01) || (JUMP_E_i == 2'b10) || br_taken;
        PCTARGET_E_o = (JUMP_E_i == 2'b10) ? ((src_a + IMM_E_i) & {{(XLEN-1){1'b1}}, 1'b0})
                                           : (PC_E_i + IMM_E_i);
    end

    assign RS1_H_o      = RS1_E_i;
    assign RS2_H_o      = RS2_E_i;
    assign RD_H_o       = RD_E_i;
    assign RSLTSRC0_H_o = RSLTSRC_E_i[0];

    always_comb begin
        alurslt_d = alu_res;
        wrtdata_d = fwd_b;
        pcplus4_d = PCPLUS4_E_i;
        rd_d      = RD_E_i;
        regwrt_d  = REGWRT_E_i;
        memwrt_d  = MEMWRT_E_i;
        rsltsrc_d = RSLTSRC_E_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alurslt_q <= '0;
            wrtdata_q <= '0;
            pcplus4_q <= '0;
            rd_q      <= '0;
            regwrt_q  <= 1'b0;
            memwrt_q  <= 1'b0;
            rsltsrc_q <= '0;
        end else begin
            alurslt_q <= alurslt_d;
            wrtdata_q <= wrtdata_d;
            pcplus4_q <= pcplus4_d;
            rd_q      <= rd_d;
            regwrt_q  <= regwrt_d;
            memwrt_q  <= memwrt_d;
            rsltsrc_q <= rsltsrc_d;
        end
    end

    assign ALURSLT_M_o = alurslt_q;
    assign WRTDATA_M_o = wrtdata_q;
    assign PCPLUS4_M_o = pcplus4_q;
    assign RD_M_o      = rd_q;
    assign REGWRT_M_o  = regwrt_q;
    assign MEMWRT_M_o  = memwrt_q;
    assign RSLTSRC_M_o = rsltsrc_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute stage of the 5-stage RV32I pipeline. It sits between the ID/EX register and the memory stage.
- Consumes ID/EX outputs and applies forwarding selects from the hazard unit.
- Performs the ALU operation and resolves branches and jumps, driving PC redirect back to fetch.
- Registers results into the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width (fixed 32 for RV32I; kept for readability).

Ports:
clk_i  input  1  clock, rising-edge.
rst_i  input  1  asynchronous active-high reset; clears EX/MEM register.
REGWRT_E_i  input  1  register-file write enable from ID/EX.
JUMP_E_i  input  2  00 none, 01 JAL, 10 JALR, 11 none.
BRANCH_E_i  input  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none.
RSLTSRC_E_i  input  2  write-back select; passed through.
MEMWRT_E_i  input  1  data-memory write enable; passed through.
ALUCTRL_E_i  input  4  ALU operation (encoding below).
ALUSRC_E_i  input  1  0 = operand B from forwarded RD2; 1 = IMM_E_i.
RD1_E_i, RD2_E_i  input  32  register operands from ID/EX.
RS1_E_i, RS2_E_i  input  5  source addresses; passed to hazard unit.
RD_E_i  input  5  destination register.
PC_E_i, IMM_E_i, PCPLUS4_E_i  input  32  PC, extended immediate, PC+4.
FWD_A_i, FWD_B_i  input  2  00 ID/EX value, 01 RESLT_DATA_W_i, 10 ALURSLT_M_o, 11 ID/EX value.
RESLT_DATA_W_i  input  32  write-back result for forwarding.
PCSRC_E_o  output  1  redirect fetch (combinational).
PCTARGET_E_o  output  32  redirect target (combinational).
RS1_H_o, RS2_H_o, RD_H_o  output  5  RS1_E_i, RS2_E_i, RD_E_i to hazard unit (combinational).
RSLTSRC0_H_o  output  1  RSLTSRC_E_i[0], load-use detect (combinational).
ALURSLT_M_o  output  32  registered ALU result.
WRTDATA_M_o  output  32  registered forwarded RD2 (store data).
RD_M_o  output  5  registered destination.
REGWRT_M_o, MEMWRT_M_o  output  1  registered controls.
RSLTSRC_M_o  output  2  registered write-back select.
PCPLUS4_M_o  output  32  registered PC+4.

Behaviour:
- Operand A: FWD_A_i mux over RD1_E_i. Forwarded B: FWD_B_i mux over RD2_E_i. Operand B: ALUSRC_E_i ? IMM_E_i : forwarded B.
- ALUCTRL_E_i encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0].
  - 1000 SLT (signed), 1001 SLTU; result is 32-bit 0 or 1.
  - 1010 PASSB (LUI).
  - Other codes give 0.
  - ADD/SUB wrap modulo 2^32; no overflow flag.
- Branch compare uses forwarded A and forwarded B, never the immediate; signed compare for BLT/BGE, unsigned for BLTU/BGEU.
- PCSRC_E_o = (JUMP_E_i==01) | (JUMP_E_i==10) | (valid branch code and condition true).
- PCTARGET_E_o:
  - JALR: (A + IMM_E_i) & 0xFFFFFFFE.
  - Otherwise: PC_E_i + IMM_E_i.
  - Valid even when PCSRC_E_o=0.
- EX/MEM register:
  - Loads every rising edge; no stall or clear (flushes are inserted upstream as ID/EX bubbles).
  - Latency: one cycle from E inputs to M outputs.
- Reset: all M outputs 0 while rst_i high, asynchronously, independent of the clock. First load occurs on the first rising edge after deassertion.
- Combinational outputs track inputs during reset; the fetch PC register is itself reset, so no redirect is taken.
- FWD=10 selects the current ALURSLT_M_o, i.e. the value registered on the previous cycle (back-to-back dependency).
- FWD_A_i and FWD_B_i are independent; both may select the same source.

Test Plan:
- Reset: rst_i=1 mid-cycle with ALURSLT_M_o=0x1234 -> all M outputs 0 immediately; after release, ADD 5+7 -> ALURSLT_M_o=12 one edge later.
- Forwarding: ALUCTRL=ADD, RD1=1, RD2=2, previous result 0x100 in M, RESLT_DATA_W_i=0x20, FWD_A=10, FWD_B=01 -> next ALURSLT_M_o=0x120, WRTDATA_M_o=0x20.
- ALU edges: SRA of 0x80000000 by 4 -> 0xF8000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; SUB 0-1 -> 0xFFFFFFFF.
- Branch: BEQ, A=B=7, PC=0x40, IMM=0xFFFFFFF8 -> PCSRC=1, PCTARGET=0x38; BNE with same operands -> PCSRC=0; ALUSRC=1 must not affect compare.
- JALR: A=0x1003, IMM=4 -> PCTARGET=0x1006, PCSRC=1; PCPLUS4 0x24 -> PCPLUS4_M_o=0x24 next edge.
- Pass-through: REGWRT=1, MEMWRT=1, RSLTSRC=10, RD=13 -> same values on M outputs after one edge; RD_H_o=13 and RSLTSRC0_H_o=0 immediately.
